// File: rtl/div_iter_ctrl_pkg.sv
// Shared types and default sizing for the iterative divider control sequencer.
package div_ctrl_pkg;

  localparam int DIV_ITER_W = 8;
  localparam int DIV_N_ITER = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_iter_ctrl.sv
// Control sequencer for the iterative divider: drives the external down counter and datapath strobes.
// Optional abort support is enabled by defining DIV_ITER_CTRL_ABORT_EN.
module div_iter_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int ITER_W = DIV_ITER_W,
  parameter int N_ITER = DIV_N_ITER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              div_by_zero_i,
  input  logic [ITER_W-1:0] cnt_q_i,
`ifdef DIV_ITER_CTRL_ABORT_EN
  input  logic              abort_i,
  output logic              aborted_o,
`endif
  output logic              cnt_ld_o,
  output logic [ITER_W-1:0] cnt_ld_data_o,
  output logic              cnt_en_o,
  output logic              dp_init_o,
  output logic              dp_step_o,
  output logic              dp_fix_o,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              dz_o,
  output div_state_e        state_o
);

  if (N_ITER < 1 || N_ITER > (2 ** ITER_W) - 1) begin : g_bad_n_iter
    $error("div_iter_ctrl: N_ITER must be in 1 .. 2**ITER_W-1");
  end

  // Handshake: a division is accepted in the cycle where ready_o && start_i;
  // done_o is a single-cycle pulse, start_i outside IDLE is dropped, not queued.

  div_state_e state_q, state_d;
  logic       dz_q;
  logic       abort;

`ifdef DIV_ITER_CTRL_ABORT_EN
  logic aborted_q;
  assign abort     = abort_i && (state_q == INIT || state_q == RUN || state_q == FIX);
  assign aborted_o = aborted_q;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_ld_o  = 1'b0;
    cnt_en_o  = 1'b0;
    dp_init_o = 1'b0;
    dp_step_o = 1'b0;
    dp_fix_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_ld_o  = 1'b1;
          dp_init_o = 1'b1;
          state_d   = INIT;
        end
      end
      INIT: state_d = div_by_zero_i ? DONE : RUN;
      RUN: begin
        // A zero count here means the counter lost sync; leave without stepping.
        if (cnt_q_i != '0) begin
          dp_step_o = 1'b1;
          cnt_en_o  = 1'b1;
        end
        if (cnt_q_i <= ITER_W'(1)) state_d = FIX;
      end
      FIX: begin
        dp_fix_o = 1'b1;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      cnt_en_o  = 1'b0;
      dp_step_o = 1'b0;
      dp_fix_o  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) dz_q <= 1'b0;
      else if (state_q == INIT && div_by_zero_i && !abort) dz_q <= 1'b1;
    end
  end

`ifdef DIV_ITER_CTRL_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) aborted_q <= 1'b0;
    else     aborted_q <= abort;
  end
`endif

  assign cnt_ld_data_o = ITER_W'(N_ITER);
  assign ready_o       = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign dz_o          = dz_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_div_iter_ctrl.sv
// Self-checking bench for div_iter_ctrl: one N_ITER=32 instance and one N_ITER=1 instance,
// each with a behavioural model of the external down counter.
module tb_div_iter_ctrl;
  import div_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-operation record: {done_cyc, steps, first_step_cyc, fix_cyc, dz}
  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  logic [32:0] exp1_q[$];
  logic [32:0] obs1_q[$];

  // ---------------- DUT A: N_ITER = 32 ----------------
  logic       start_a = 1'b0, dbz = 1'b0;
  logic [7:0] cnt_a = 8'd0;
  logic       a_ld, a_en, a_init, a_step, a_fix, a_ready, a_busy, a_done, a_dz;
  logic [7:0] a_ld_data;
  div_state_e a_state;
`ifdef DIV_ITER_CTRL_ABORT_EN
  logic abort_a = 1'b0, a_aborted, b_aborted;
`endif

  div_iter_ctrl #(.ITER_W(8), .N_ITER(32)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .div_by_zero_i(dbz), .cnt_q_i(cnt_a),
`ifdef DIV_ITER_CTRL_ABORT_EN
    .abort_i(abort_a), .aborted_o(a_aborted),
`endif
    .cnt_ld_o(a_ld), .cnt_ld_data_o(a_ld_data), .cnt_en_o(a_en), .dp_init_o(a_init),
    .dp_step_o(a_step), .dp_fix_o(a_fix), .ready_o(a_ready), .busy_o(a_busy),
    .done_o(a_done), .dz_o(a_dz), .state_o(a_state)
  );

  always @(posedge clk) begin
    if (a_ld) cnt_a <= a_ld_data;
    else if (a_en) cnt_a <= cnt_a - 8'd1;
  end

  // ---------------- DUT B: N_ITER = 1 ----------------
  logic       start_b = 1'b0, force_zero = 1'b0;
  logic [7:0] cnt_b = 8'd0;
  logic [7:0] cnt_b_q;
  logic       b_ld, b_en, b_init, b_step, b_fix, b_ready, b_busy, b_done, b_dz;
  logic [7:0] b_ld_data;
  div_state_e b_state;
  assign cnt_b_q = force_zero ? 8'd0 : cnt_b;

  div_iter_ctrl #(.ITER_W(8), .N_ITER(1)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .div_by_zero_i(1'b0), .cnt_q_i(cnt_b_q),
`ifdef DIV_ITER_CTRL_ABORT_EN
    .abort_i(1'b0), .aborted_o(b_aborted),
`endif
    .cnt_ld_o(b_ld), .cnt_ld_data_o(b_ld_data), .cnt_en_o(b_en), .dp_init_o(b_init),
    .dp_step_o(b_step), .dp_fix_o(b_fix), .ready_o(b_ready), .busy_o(b_busy),
    .done_o(b_done), .dz_o(b_dz), .state_o(b_state)
  );

  always @(posedge clk) begin
    if (b_ld) cnt_b <= b_ld_data;
    else if (b_en) cnt_b <= cnt_b - 8'd1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitors (sample on falling edge) ----------------
  int       gcyc = 0, last_done_g = -10, b2b = 0;
  bit       act_a = 0, act_b = 0;
  int       cyc_a, cyc_b;
  logic [7:0] st_a, fs_a, fx_a, st_b, fs_b, fx_b;

  always @(negedge clk) begin
    gcyc++;
    if (rst) act_a = 0;
    else begin
`ifdef DIV_ITER_CTRL_ABORT_EN
      if (a_aborted) act_a = 0;
`endif
      if (act_a) begin
        cyc_a++;
        if (a_step) begin st_a++; if (fs_a == 8'hFF) fs_a = 8'(cyc_a); end
        if (a_fix) fx_a = 8'(cyc_a);
        if (a_done) begin
          obs_q.push_back({8'(cyc_a), st_a, fs_a, fx_a, a_dz});
          last_done_g = gcyc;
          act_a = 0;
        end
      end
      if (a_ld) begin
        if (gcyc == last_done_g + 1) b2b++;
        act_a = 1; cyc_a = 0; st_a = 0; fs_a = 8'hFF; fx_a = 8'hFF;
      end
      check("a_ld_en_excl", 64'(a_ld && a_en), 64'd0);
      check("a_ld_while_busy", 64'(a_ld && a_busy), 64'd0);
    end
  end

  always @(negedge clk) begin
    if (rst) act_b = 0;
    else begin
      if (act_b) begin
        cyc_b++;
        if (b_step) begin st_b++; if (fs_b == 8'hFF) fs_b = 8'(cyc_b); end
        if (b_fix) fx_b = 8'(cyc_b);
        if (b_done) begin
          obs1_q.push_back({8'(cyc_b), st_b, fs_b, fx_b, b_dz});
          act_b = 0;
        end
      end
      if (b_ld) begin
        act_b = 1; cyc_b = 0; st_b = 0; fs_b = 8'hFF; fx_b = 8'hFF;
      end
      check("b_ld_en_excl", 64'(b_ld && b_en), 64'd0);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic expect_op(input string tag, input bit which);
    int t;
    logic [32:0] e, o;
    t = 0;
    while (((which == 1'b0) ? obs_q.size() : obs1_q.size()) == 0 && t < 200) begin
      cyc(); t++;
    end
    if (which == 1'b0) begin
      check({tag, "_avail"}, 64'(obs_q.size() != 0), 64'd1);
      e = exp_q.pop_front();
      if (obs_q.size() != 0) begin o = obs_q.pop_front(); check(tag, 64'(o), 64'(e)); end
    end else begin
      check({tag, "_avail"}, 64'(obs1_q.size() != 0), 64'd1);
      e = exp1_q.pop_front();
      if (obs1_q.size() != 0) begin o = obs1_q.pop_front(); check(tag, 64'(o), 64'(e)); end
    end
  endtask

  localparam logic [32:0] EXP_FULL  = {8'd35, 8'd32, 8'd2, 8'd34, 1'b0};
  localparam logic [32:0] EXP_DZ    = {8'd2, 8'd0, 8'hFF, 8'hFF, 1'b1};
  localparam logic [32:0] EXP_ONE   = {8'd4, 8'd1, 8'd2, 8'd3, 1'b0};
  localparam logic [32:0] EXP_ZERO  = {8'd4, 8'd0, 8'hFF, 8'd3, 1'b0};

  initial begin
    int b2b_before, t;

    // reset
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(a_ready), 64'd1);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_dz", 64'(a_dz), 64'd0);
    check("rst_done", 64'(a_done), 64'd0);
    check("rst_strobes", 64'({a_ld, a_en, a_init, a_step, a_fix}), 64'd0);
    check("rst_state", 64'(a_state), 64'(IDLE));
    check("ld_data_a", 64'(a_ld_data), 64'd32);
    check("ld_data_b", 64'(b_ld_data), 64'd1);
    cyc();

    // 1: full 32-step division
    exp_q.push_back(EXP_FULL);
    start_a = 1'b1;
    @(negedge clk);
    check("t1_ld_init", 64'({a_ld, a_init}), 64'b11);
    cyc();
    start_a = 1'b0;
    expect_op("t1_op", 1'b0);
    repeat (3) cyc();

    // 2: divide by zero, then dz_o cleared by the next accepted start
    exp_q.push_back(EXP_DZ);
    dbz = 1'b1; start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    expect_op("t2_dz_op", 1'b0);
    dbz = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    check("t2_dz_held", 64'(a_dz), 64'd1);
    cyc();
    exp_q.push_back(EXP_FULL);
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    @(negedge clk);
    check("t2_dz_cleared", 64'(a_dz), 64'd0);
    expect_op("t2_next_op", 1'b0);
    repeat (3) cyc();

    // 3: start held high -> back-to-back operations
    b2b_before = b2b;
    repeat (3) exp_q.push_back(EXP_FULL);
    start_a = 1'b1;
    t = 0;
    while (obs_q.size() < 3 && t < 300) begin cyc(); t++; end
    start_a = 1'b0;
    expect_op("t3_op0", 1'b0);
    expect_op("t3_op1", 1'b0);
    expect_op("t3_op2", 1'b0);
    check("t3_back_to_back", 64'(b2b - b2b_before), 64'd2);
    repeat (3) cyc();
    @(negedge clk);
    check("t3_idle_after", 64'(a_ready), 64'd1);
    cyc();

    // 4: reset during RUN, then a fresh division
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    repeat (9) cyc();
    rst = 1'b1;
    @(negedge clk);
    check("t4_in_run", 64'(a_state), 64'(RUN));
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("t4_ready", 64'(a_ready), 64'd1);
    check("t4_busy", 64'(a_busy), 64'd0);
    check("t4_quiet", 64'({a_done, a_step, a_en, a_fix, a_dz}), 64'd0);
    repeat (40) cyc();
    check("t4_no_done", 64'(obs_q.size()), 64'd0);
    exp_q.push_back(EXP_FULL);
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    expect_op("t4_fresh_op", 1'b0);
    repeat (3) cyc();

    // 5: N_ITER=1, then a counter stuck at zero on RUN entry
    exp1_q.push_back(EXP_ONE);
    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    expect_op("t5_one_step", 1'b1);
    repeat (3) cyc();
    exp1_q.push_back(EXP_ZERO);
    force_zero = 1'b1;
    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    expect_op("t5_zero_cnt", 1'b1);
    force_zero = 1'b0;
    repeat (3) cyc();

`ifdef DIV_ITER_CTRL_ABORT_EN
    // 6: abort during RUN
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    repeat (4) cyc();
    abort_a = 1'b1;
    @(negedge clk);
    check("t6_abort_no_step", 64'({a_step, a_en, a_fix}), 64'd0);
    cyc();
    abort_a = 1'b0;
    @(negedge clk);
    check("t6_aborted_pulse", 64'(a_aborted), 64'd1);
    check("t6_idle", 64'(a_ready), 64'd1);
    cyc();
    @(negedge clk);
    check("t6_aborted_drop", 64'(a_aborted), 64'd0);
    repeat (40) cyc();
    check("t6_no_done", 64'(obs_q.size()), 64'd0);
`endif

    check("exp_q_drained", 64'(exp_q.size() + exp1_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
